cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Two-requester arbiter sharing the single upstream port (ufp) of the unified cache between the instruction-fetch requester (I) and the data-memory requester (D). Requests arrive as one-cycle mask pulses, losers are buffered in a per-requester pending slot, and exactly one request is outstanding at the cache at a time. The response is routed back to the owner combinationally. Ties use round-robin priority.

## Interface
- ADDR_WIDTH, 32, byte address width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_addr / d_addr  in  ADDR_WIDTH  requester address, word aligned
- i_rmask / d_rmask  in  4  read byte mask; nonzero for one cycle = read request
- i_wmask / d_wmask  in  4  write byte mask; nonzero for one cycle = write request
- i_wdata / d_wdata  in  32  write data
- i_rdata / d_rdata  out  32  read data; equals ufp_rdata
- i_resp / d_resp  out  1  completion pulse to owner
- ufp_addr  out  ADDR_WIDTH  registered address to cache
- ufp_rmask / ufp_wmask  out  4  registered masks; nonzero for exactly one cycle per request
- ufp_wdata  out  32  registered write data
- ufp_rdata  in  32  cache read data, valid with ufp_resp
- ufp_resp  in  1  cache completion pulse
- err  out  1  sticky protocol-violation flag

## Operation
- A request is any cycle with rmask≠0 or wmask≠0. rmask and wmask nonzero together is a violation: the request is dropped and err is set.
- State per requester: pending slot {valid, addr, rmask, wmask, wdata}. Global state: IDLE/BUSY, owner (I/D), last_grant.
- Candidate per requester = the pending slot if valid, else that requester's request in the current cycle.
- IDLE edge: if any candidate exists, pick the winner. With one candidate, that candidate wins. With both, the requester ≠ last_grant wins. The winner is loaded into the ufp registers, owner and last_grant ← winner, state goes to BUSY. A losing new request is written to its pending slot. The winner's pending slot is cleared if it was the source.
- BUSY: ufp_rmask/ufp_wmask are zeroed after their first cycle. ufp_addr and ufp_wdata are held until the response. New requests from the non-owner go to its pending slot.
- Response cycle (BUSY and ufp_resp): owner's resp = 1 and rdata = ufp_rdata in the same cycle. The same edge applies the IDLE-edge rule, so the next request can issue back-to-back. Otherwise the state returns to IDLE.
- Violations, each setting err with the offending request dropped and existing state unchanged:
  - new request from the owner while BUSY (before its resp);
  - new request from a requester whose pending slot is valid;
  - ufp_resp while IDLE.
- A new request from the owner in its own response cycle is legal; it is treated as a candidate at that edge.
- i_resp/d_resp are never both 1. The non-owner's resp is 0. rdata outputs equal ufp_rdata unconditionally.

## Timing
- Reset, asynchronous, any state: IDLE, both pending slots invalid, ufp_addr=0, ufp_rmask=0, ufp_wmask=0, ufp_wdata=0, err=0, last_grant=D so I wins the first tie. i_resp=d_resp=0 because the block is not BUSY.
- Reset mid-transaction abandons the transaction. A later stray ufp_resp is treated as a violation.
- Latency, request to ufp mask pulse: 1 cycle when the arbiter is IDLE and the request wins.
- Latency, ufp_resp to requester resp: 0 cycles (combinational).
- A loser waits for the winner's ufp_resp; it issues in the cycle after that resp.
- Throughput: one request per (cache latency + 1) cycles. There are no idle bubbles between back-to-back transactions.
- err stays at 1 until reset.

## Test plan
- Single read: cycle 0 d_rmask=4'hF, d_addr=0x100. Expect cycle 1 ufp_rmask=4'hF, ufp_addr=0x100; cycle 2 ufp_rmask=0. Cache resp at cycle 4 with rdata=0xDEADBEEF. Expect d_resp=1 and d_rdata=0xDEADBEEF in cycle 4, i_resp=0.
- Simultaneous after reset: I read 0x40 and D write 0x80 (wmask=4'h3, wdata=0x1234) in cycle 0. Expect I issued cycle 1. D stays pending and issues in the cycle after I's resp with ufp_wmask=4'h3, ufp_wdata=0x1234. A second tie is then won by I, since last_grant=D after D was served.
- Back-to-back: I requests again in the cycle of its own resp while D is pending. Expect D issued first (round-robin), then I. No idle cycle between resp and the next ufp mask pulse.
- Violations: owner D requests while BUSY, then ufp_resp while IDLE. Expect err=1 after the first violation, no extra ufp pulse, the outstanding transaction still completing normally, and err staying at 1.
- Reset mid-operation: assert rst_n=0 while BUSY with D pending. Expect all outputs at their reset values immediately. After release, a new I request issues in 1 cycle.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Arbitrates the unified cache's single upstream port between instruction fetch (I) and data (D).
// Losing requests wait in a per-requester pending slot; ties are settled round-robin.
module cache_port_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [3:0]            i_rmask,
    input  logic [3:0]            i_wmask,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           i_rdata,
    output logic                  i_resp,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [3:0]            d_rmask,
    input  logic [3:0]            d_wmask,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_resp,

    output logic [ADDR_WIDTH-1:0] ufp_addr,
    output logic [3:0]            ufp_rmask,
    output logic [3:0]            ufp_wmask,
    output logic [31:0]           ufp_wdata,
    input  logic [31:0]           ufp_rdata,
    input  logic                  ufp_resp,

    output logic                  err
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  lastGrant_q, lastGrant_d;
    logic                  err_q, err_d;

    logic [1:0]            pendValid_q, pendValid_d;
    logic [ADDR_WIDTH-1:0] pendAddr_q  [2];
    logic [ADDR_WIDTH-1:0] pendAddr_d  [2];
    logic [3:0]            pendRmask_q [2];
    logic [3:0]            pendRmask_d [2];
    logic [3:0]            pendWmask_q [2];
    logic [3:0]            pendWmask_d [2];
    logic [31:0]           pendWdata_q [2];
    logic [31:0]           pendWdata_d [2];

    logic [ADDR_WIDTH-1:0] ufpAddr_q, ufpAddr_d;
    logic [3:0]            ufpRmask_q, ufpRmask_d;
    logic [3:0]            ufpWmask_q, ufpWmask_d;
    logic [31:0]           ufpWdata_q, ufpWdata_d;

    logic [ADDR_WIDTH-1:0] reqAddr  [2];
    logic [3:0]            reqRmask [2];
    logic [3:0]            reqWmask [2];
    logic [31:0]           reqWdata [2];

    logic [1:0]            hasReq;
    logic [1:0]            ownerBusy;
    logic [1:0]            reqViol;
    logic [1:0]            newOk;
    logic [1:0]            cand;
    logic                  respNow;
    logic                  issueEn;
    logic                  grant;
    logic                  winner;

    assign reqAddr[0]  = i_addr;
    assign reqAddr[1]  = d_addr;
    assign reqRmask[0] = i_rmask;
    assign reqRmask[1] = d_rmask;
    assign reqWmask[0] = i_wmask;
    assign reqWmask[1] = d_wmask;
    assign reqWdata[0] = i_wdata;
    assign reqWdata[1] = d_wdata;

    // A new request is usable only if it is well-formed, its slot is free and its
    // requester is not waiting on its own transaction (its response cycle is allowed).
    always_comb begin
        respNow = (state_q == BUSY) && ufp_resp;
        issueEn = (state_q == IDLE) || respNow;
        for (int r = 0; r < 2; r++) begin
            hasReq[r]    = (|reqRmask[r]) || (|reqWmask[r]);
            ownerBusy[r] = (state_q == BUSY) && !ufp_resp && (owner_q == r[0]);
            reqViol[r]   = hasReq[r] && (((|reqRmask[r]) && (|reqWmask[r]))
                                         || pendValid_q[r] || ownerBusy[r]);
            newOk[r]     = hasReq[r] && !reqViol[r];
            cand[r]      = pendValid_q[r] || newOk[r];
        end
        if (cand[0] && cand[1]) begin
            winner = ~lastGrant_q;
        end else begin
            winner = cand[1] ? REQ_D : REQ_I;
        end
        grant = issueEn && (|cand);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        pendValid_d = pendValid_q;
        pendAddr_d  = pendAddr_q;
        pendRmask_d = pendRmask_q;
        pendWmask_d = pendWmask_q;
        pendWdata_d = pendWdata_q;
        ufpAddr_d   = ufpAddr_q;
        ufpWdata_d  = ufpWdata_q;
        ufpRmask_d  = '0;
        ufpWmask_d  = '0;
        err_d       = err_q || (|reqViol) || ((state_q == IDLE) && ufp_resp);

        if (grant) begin
            state_d     = BUSY;
            owner_d     = winner;
            lastGrant_d = winner;
            if (pendValid_q[winner]) begin
                ufpAddr_d  = pendAddr_q[winner];
                ufpRmask_d = pendRmask_q[winner];
                ufpWmask_d = pendWmask_q[winner];
                ufpWdata_d = pendWdata_q[winner];
            end else begin
                ufpAddr_d  = reqAddr[winner];
                ufpRmask_d = reqRmask[winner];
                ufpWmask_d = reqWmask[winner];
                ufpWdata_d = reqWdata[winner];
            end
            pendValid_d[winner] = 1'b0;
        end else if (respNow) begin
            state_d = IDLE;
        end

        for (int r = 0; r < 2; r++) begin
            if (newOk[r] && !(grant && (winner == r[0]))) begin
                pendValid_d[r] = 1'b1;
                pendAddr_d[r]  = reqAddr[r];
                pendRmask_d[r] = reqRmask[r];
                pendWmask_d[r] = reqWmask[r];
                pendWdata_d[r] = reqWdata[r];
            end
        end
    end

    // last_grant resets to D so that I wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= REQ_I;
            lastGrant_q <= REQ_D;
            pendValid_q <= '0;
            ufpAddr_q   <= '0;
            ufpRmask_q  <= '0;
            ufpWmask_q  <= '0;
            ufpWdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            pendValid_q <= pendValid_d;
            ufpAddr_q   <= ufpAddr_d;
            ufpRmask_q  <= ufpRmask_d;
            ufpWmask_q  <= ufpWmask_d;
            ufpWdata_q  <= ufpWdata_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        pendAddr_q  <= pendAddr_d;
        pendRmask_q <= pendRmask_d;
        pendWmask_q <= pendWmask_d;
        pendWdata_q <= pendWdata_d;
    end

    assign ufp_addr  = ufpAddr_q;
    assign ufp_rmask = ufpRmask_q;
    assign ufp_wmask = ufpWmask_q;
    assign ufp_wdata = ufpWdata_q;
    assign err       = err_q;

    assign i_resp  = respNow && (owner_q == REQ_I);
    assign d_resp  = respNow && (owner_q == REQ_D);
    assign i_rdata = ufp_rdata;
    assign d_rdata = ufp_rdata;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: expected ufp issues are queued as requests are
// driven and compared against every mask pulse the arbiter produces.
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_addr, d_addr, i_wdata, d_wdata, i_rdata, d_rdata;
    logic [3:0]  i_rmask, i_wmask, d_rmask, d_wmask;
    logic        i_resp, d_resp;
    logic [31:0] ufp_addr, ufp_wdata, ufp_rdata;
    logic [3:0]  ufp_rmask, ufp_wmask;
    logic        ufp_resp, err;

    int          total = 0;
    int          bad   = 0;
    logic [71:0] expIssue [$];

    cache_port_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_rmask(i_rmask), .i_wmask(i_wmask), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask),
        .ufp_wdata(ufp_wdata), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every ufp mask pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (ufp_rmask != 4'h0 || ufp_wmask != 4'h0)) begin
            if (expIssue.size() == 0)
                checkOutput("unexpectedIssue", {ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata}, 72'd0);
            else
                checkOutput("issue", {ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata}, expIssue.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clearReq();
        i_addr = '0; i_rmask = '0; i_wmask = '0; i_wdata = '0;
        d_addr = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
    endtask

    task automatic applyStimulus(input logic isD, input logic [31:0] addr,
                                 input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd);
        if (isD) begin
            d_addr = addr; d_rmask = rm; d_wmask = wm; d_wdata = wd;
        end else begin
            i_addr = addr; i_rmask = rm; i_wmask = wm; i_wdata = wd;
        end
    endtask

    task automatic expectIssue(input logic [31:0] addr, input logic [3:0] rm,
                               input logic [3:0] wm, input logic [31:0] wd);
        expIssue.push_back({addr, rm, wm, wd});
    endtask

    // Cache completes the outstanding transaction in the current cycle.
    task automatic cacheResp(input logic [31:0] data, input logic expI, input logic expD);
        ufp_resp  = 1'b1;
        ufp_rdata = data;
        mid();
        checkOutput("iResp", i_resp, expI);
        checkOutput("dResp", d_resp, expD);
        checkOutput("iRdata", i_rdata, data);
        checkOutput("dRdata", d_rdata, data);
        step();
        ufp_resp = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearReq();
        ufp_resp = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ufp_resp = 1'b0;
        ufp_rdata = '0;
        clearReq();
        #2;
        checkOutput("rstAddr", ufp_addr, 0);
        checkOutput("rstMasks", {ufp_rmask, ufp_wmask}, 0);
        checkOutput("rstWdata", ufp_wdata, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstResp", {i_resp, d_resp}, 0);
        step();
        step();
        rst_n = 1'b1;

        // Single D read with a 3-cycle cache.
        applyStimulus(1'b1, 32'h100, 4'hF, 4'h0, 32'h0);
        expectIssue(32'h100, 4'hF, 4'h0, 32'h0);
        step(); clearReq();
        mid();
        checkOutput("t1RmaskC1", ufp_rmask, 4'hF);
        checkOutput("t1AddrC1", ufp_addr, 32'h100);
        step();
        mid();
        checkOutput("t1RmaskC2", ufp_rmask, 4'h0);
        checkOutput("t1AddrHeld", ufp_addr, 32'h100);
        step();
        step();
        cacheResp(32'hDEADBEEF, 1'b0, 1'b1);

        // Simultaneous requests after reset, then round-robin and back-to-back.
        doReset();
        applyStimulus(1'b0, 32'h40, 4'hF, 4'h0, 32'h0);
        applyStimulus(1'b1, 32'h80, 4'h0, 4'h3, 32'h1234);
        expectIssue(32'h40, 4'hF, 4'h0, 32'h0);
        expectIssue(32'h80, 4'h0, 4'h3, 32'h1234);
        step(); clearReq();
        mid();
        checkOutput("t2IFirst", ufp_rmask, 4'hF);
        step();
        step();
        cacheResp(32'h11111111, 1'b1, 1'b0);
        mid();
        checkOutput("t2DWmask", ufp_wmask, 4'h3);
        checkOutput("t2DWdata", ufp_wdata, 32'h1234);
        checkOutput("t2DAddr", ufp_addr, 32'h80);
        step();
        cacheResp(32'h22222222, 1'b0, 1'b1);

        applyStimulus(1'b0, 32'h44, 4'hF, 4'h0, 32'h0);
        applyStimulus(1'b1, 32'h84, 4'hF, 4'h0, 32'h0);
        expectIssue(32'h44, 4'hF, 4'h0, 32'h0);
        expectIssue(32'h84, 4'hF, 4'h0, 32'h0);
        expectIssue(32'h48, 4'hF, 4'h0, 32'h0);
        step(); clearReq();
        mid();
        checkOutput("t3TieI", ufp_addr, 32'h44);
        step();
        applyStimulus(1'b0, 32'h48, 4'hF, 4'h0, 32'h0);
        cacheResp(32'h33333333, 1'b1, 1'b0);
        clearReq();
        mid();
        checkOutput("t3DNoBubble", {ufp_addr, ufp_rmask}, {32'h84, 4'hF});
        step();
        cacheResp(32'h44444444, 1'b0, 1'b1);
        mid();
        checkOutput("t3INoBubble", {ufp_addr, ufp_rmask}, {32'h48, 4'hF});
        step();
        cacheResp(32'h55555555, 1'b1, 1'b0);
        checkOutput("t3ErrClean", err, 1'b0);

        // Owner request while busy, then stray response while idle.
        doReset();
        applyStimulus(1'b1, 32'h200, 4'hF, 4'h0, 32'h0);
        expectIssue(32'h200, 4'hF, 4'h0, 32'h0);
        step(); clearReq();
        mid();
        checkOutput("t4ErrBefore", err, 1'b0);
        step();
        applyStimulus(1'b1, 32'h204, 4'hF, 4'h0, 32'h0);
        step(); clearReq();
        mid();
        checkOutput("t4ErrSet", err, 1'b1);
        checkOutput("t4NoExtra", ufp_rmask, 4'h0);
        step();
        cacheResp(32'h66666666, 1'b0, 1'b1);
        ufp_resp = 1'b1;
        mid();
        checkOutput("t4StrayResp", {i_resp, d_resp}, 2'b00);
        step();
        ufp_resp = 1'b0;
        mid();
        checkOutput("t4ErrSticky", err, 1'b1);
        checkOutput("t4IdleMask", ufp_rmask, 4'h0);
        step();

        // Reset while busy with D pending abandons both.
        doReset();
        applyStimulus(1'b0, 32'h60, 4'hF, 4'h0, 32'h0);
        applyStimulus(1'b1, 32'h90, 4'h0, 4'hF, 32'hCAFE);
        expectIssue(32'h60, 4'hF, 4'h0, 32'h0);
        step(); clearReq();
        mid();
        checkOutput("t5IIssued", ufp_addr, 32'h60);
        step();
        rst_n = 1'b0;
        ufp_resp = 1'b1;
        #1;
        checkOutput("t5RstAddr", ufp_addr, 0);
        checkOutput("t5RstMasks", {ufp_rmask, ufp_wmask}, 0);
        checkOutput("t5RstWdata", ufp_wdata, 0);
        checkOutput("t5RstResp", {i_resp, d_resp}, 0);
        step();
        ufp_resp = 1'b0;
        step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h64, 4'hF, 4'h0, 32'h0);
        expectIssue(32'h64, 4'hF, 4'h0, 32'h0);
        step(); clearReq();
        mid();
        checkOutput("t5PostRstIssue", {ufp_addr, ufp_rmask}, {32'h64, 4'hF});
        step();
        step();
        cacheResp(32'h77777777, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step();
        checkOutput("sbEmpty", expIssue.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
